axi4l_mem_initiator: RTL and testbench

- AXI4-lite initiator that converts the core-side native memory port (valid/ready, addr, wdata, wstrb, instr) into single AXI4-lite read or write transactions.
- It is the requesting end of the AXI4-lite link that the testbench memory model answers.
- One transaction is in flight at a time. AW and W channels are tracked independently.
- A watchdog counter flags responders that never answer.

---
 rtl/axi4l_pkg.sv | 18 +
 rtl/axi4l_mem_initiator_if.sv | 63 ++++++
 rtl/axi4l_watchdog.sv | 41 ++++
 rtl/axi4l_mem_initiator.sv | 163 ++++++++++++++++
 tb/tb_axi4l_mem_initiator.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4l_pkg.sv
// Shared types and constants for the AXI4-lite memory initiator and its helpers.
package axi4l_pkg;

  localparam int unsigned AXI_WIDTH = 32;

  localparam logic [2:0] PROT_DATA = 3'b000;
  localparam logic [2:0] PROT_INSN = 3'b100;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWr,
    StWrResp,
    StDone
  } state_e;

endpackage

// File: rtl/axi4l_mem_initiator_if.sv
// Native core memory port plus AXI4-lite initiator channels, bundled for the initiator.
interface axi4l_mem_initiator_if;
  import axi4l_pkg::*;

  logic                   mem_valid;
  logic                   mem_instr;
  logic [AXI_WIDTH-1:0]   mem_addr;
  logic [AXI_WIDTH-1:0]   mem_wdata;
  logic [AXI_WIDTH/8-1:0] mem_wstrb;
  logic                   mem_ready;
  logic [AXI_WIDTH-1:0]   mem_rdata;

  logic                   mem_axi_awvalid;
  logic                   mem_axi_awready;
  logic [AXI_WIDTH-1:0]   mem_axi_awaddr;
  logic [2:0]             mem_axi_awprot;
  logic                   mem_axi_wvalid;
  logic                   mem_axi_wready;
  logic [AXI_WIDTH-1:0]   mem_axi_wdata;
  logic [AXI_WIDTH/8-1:0] mem_axi_wstrb;
  logic                   mem_axi_bvalid;
  logic                   mem_axi_bready;
  logic                   mem_axi_arvalid;
  logic                   mem_axi_arready;
  logic [AXI_WIDTH-1:0]   mem_axi_araddr;
  logic [2:0]             mem_axi_arprot;
  logic                   mem_axi_rvalid;
  logic                   mem_axi_rready;
  logic [AXI_WIDTH-1:0]   mem_axi_rdata;

  // Initiator view.
  modport master (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_awready,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_wready,
    input  mem_axi_bvalid,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    input  mem_axi_arready,
    input  mem_axi_rvalid, mem_axi_rdata,
    output mem_axi_rready
  );

  // Core plus responder view.
  modport slave (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_awready,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_wready,
    output mem_axi_bvalid,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    output mem_axi_arready,
    output mem_axi_rvalid, mem_axi_rdata,
    input  mem_axi_rready
  );

endinterface

// File: rtl/axi4l_watchdog.sv
// Saturating wait counter with a sticky flag once the count reaches TIMEOUT_CYCLES.
module axi4l_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam logic [CNT_WIDTH-1:0] Limit = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 flag_q, flag_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Flag rises on the same edge the count lands on the limit.
    flag_d = flag_q | ((TIMEOUT_CYCLES != 0) && (cnt_d == Limit) && !clr_i);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign expired_o = flag_q;

endmodule

// File: rtl/axi4l_mem_initiator.sv
// Converts single native memory requests into one AXI4-lite read or write at a time.
module axi4l_mem_initiator
  import axi4l_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  axi4l_mem_initiator_if.master bus,
  output logic                  timeout_err,
  output logic                  busy
);

  state_e                 state_q, state_d;
  logic [AXI_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [2:0]             prot_q, prot_d;
  logic [AXI_WIDTH-1:0]   rdata_q, rdata_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic rready_q, rready_d, bready_q, bready_d, mem_ready_q, mem_ready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, busy_q, busy_d;
  logic aw_hs, w_hs;

  assign aw_hs = awvalid_q & bus.mem_axi_awready;
  assign w_hs  = wvalid_q & bus.mem_axi_wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    prot_d      = prot_q;
    rdata_d     = rdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    bready_d    = bready_q;
    mem_ready_d = 1'b0;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_valid) begin
          addr_d    = bus.mem_addr;
          wdata_d   = bus.mem_wdata;
          wstrb_d   = bus.mem_wstrb;
          prot_d    = bus.mem_instr ? PROT_INSN : PROT_DATA;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (bus.mem_wstrb == '0) begin
            arvalid_d = 1'b1;
            state_d   = StRdAddr;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end
        end
      end
      StRdAddr: begin
        if (arvalid_q && bus.mem_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (rready_q && bus.mem_axi_rvalid) begin
          rdata_d     = bus.mem_axi_rdata;
          rready_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = StDone;
        end
      end
      StWr: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end
      end
      StWrResp: begin
        if (bready_q && bus.mem_axi_bvalid) begin
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= PROT_DATA;
      rdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      prot_q      <= prot_d;
      rdata_q     <= rdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      bready_q    <= bready_d;
      mem_ready_q <= mem_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      busy_q      <= busy_d;
    end
  end

  axi4l_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_watchdog (
    .clk      (clk),
    .resetn   (resetn),
    .en_i     ((state_q != StIdle) && (state_q != StDone)),
    .clr_i    ((state_q == StIdle) || (state_q == StDone)),
    .expired_o(timeout_err)
  );

  assign busy                = busy_q;
  assign bus.mem_ready       = mem_ready_q;
  assign bus.mem_rdata       = rdata_q;
  assign bus.mem_axi_awvalid = awvalid_q;
  assign bus.mem_axi_awaddr  = addr_q;
  assign bus.mem_axi_awprot  = PROT_DATA;
  assign bus.mem_axi_wvalid  = wvalid_q;
  assign bus.mem_axi_wdata   = wdata_q;
  assign bus.mem_axi_wstrb   = wstrb_q;
  assign bus.mem_axi_bready  = bready_q;
  assign bus.mem_axi_arvalid = arvalid_q;
  assign bus.mem_axi_araddr  = addr_q;
  assign bus.mem_axi_arprot  = prot_q;
  assign bus.mem_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4l_mem_initiator.sv
// Directed bench: core driver, latency-configurable AXI4-lite memory, read-data scoreboard.
module tb_axi4l_mem_initiator;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic timeout_err, busy;

  axi4l_mem_initiator_if bus();

  axi4l_mem_initiator #(
    .TIMEOUT_CYCLES(8),
    .CNT_WIDTH     (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder knobs and observation records.
  int ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0;
  bit ar_block = 0;
  logic [31:0] mem [256];
  int ar_n = 0, aw_n = 0, w_n = 0, b_n = 0, aw_hi = 0, w_hi = 0;
  int ar_hs_cyc, aw_hs_cyc, w_hs_cyc, b_hs_cyc, bready_rise_cyc, arvalid_rise_cyc;
  logic [2:0] last_arprot;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory responder: decides readies at negedges, so every handshake is known one
  // half-cycle before the posedge that completes it.
  initial begin
    int ar_cnt, aw_cnt, w_cnt, r_wait;
    bit r_pend, r_hs, b_pend, b_hs, aw_got, w_got, bready_prev, arvalid_prev;
    logic [31:0] r_addr, aw_addr_l, w_data_l;
    logic [3:0] w_strb_l;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus.mem_axi_arready = 0; bus.mem_axi_awready = 0; bus.mem_axi_wready = 0;
        bus.mem_axi_rvalid = 0; bus.mem_axi_bvalid = 0; bus.mem_axi_rdata = '0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_wait = 0;
        r_pend = 0; r_hs = 0; b_pend = 0; b_hs = 0; aw_got = 0; w_got = 0;
        bready_prev = 0; arvalid_prev = 0;
      end else begin
        if (r_hs) begin bus.mem_axi_rvalid = 0; r_hs = 0; end
        if (r_pend) begin
          if (r_wait >= r_lat) begin
            bus.mem_axi_rvalid = 1; bus.mem_axi_rdata = mem[r_addr[9:2]]; r_pend = 0;
          end else r_wait++;
        end
        if (bus.mem_axi_rvalid && bus.mem_axi_rready) r_hs = 1;
        if (b_hs) begin bus.mem_axi_bvalid = 0; b_hs = 0; end
        if (b_pend) begin bus.mem_axi_bvalid = 1; b_pend = 0; end
        if (bus.mem_axi_bvalid && bus.mem_axi_bready) begin
          b_hs = 1; b_n++; b_hs_cyc = cyc;
        end
        if (bus.mem_axi_bready && !bready_prev) bready_rise_cyc = cyc;
        bready_prev = bus.mem_axi_bready;
        if (bus.mem_axi_arvalid && !arvalid_prev) arvalid_rise_cyc = cyc;
        arvalid_prev = bus.mem_axi_arvalid;

        bus.mem_axi_arready = bus.mem_axi_arvalid && !ar_block && (ar_cnt >= ar_lat);
        ar_cnt = bus.mem_axi_arvalid ? ar_cnt + 1 : 0;
        if (bus.mem_axi_arready) begin
          r_pend = 1; r_wait = 0; r_addr = bus.mem_axi_araddr;
          last_arprot = bus.mem_axi_arprot; ar_n++; ar_hs_cyc = cyc; ar_cnt = 0;
        end

        if (bus.mem_axi_awvalid) aw_hi++;
        if (bus.mem_axi_wvalid) w_hi++;
        bus.mem_axi_awready = bus.mem_axi_awvalid && (aw_cnt >= aw_lat);
        aw_cnt = bus.mem_axi_awvalid ? aw_cnt + 1 : 0;
        if (bus.mem_axi_awready) begin
          aw_got = 1; aw_addr_l = bus.mem_axi_awaddr; aw_n++; aw_hs_cyc = cyc; aw_cnt = 0;
        end
        bus.mem_axi_wready = bus.mem_axi_wvalid && (w_cnt >= w_lat);
        w_cnt = bus.mem_axi_wvalid ? w_cnt + 1 : 0;
        if (bus.mem_axi_wready) begin
          w_got = 1; w_data_l = bus.mem_axi_wdata; w_strb_l = bus.mem_axi_wstrb;
          w_n++; w_hs_cyc = cyc; w_cnt = 0;
        end
        if (aw_got && w_got) begin
          for (int i = 0; i < 4; i++)
            if (w_strb_l[i]) mem[aw_addr_l[9:2]][i*8 +: 8] = w_data_l[i*8 +: 8];
          aw_got = 0; w_got = 0; b_pend = 1;
        end
      end
    end
  end

  // Drives one request from a negedge, waits (bounded) for mem_ready, scores read data.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit instr, input bit keep,
                        output int lat, output int done_cyc);
    bit seen;
    logic [31:0] exp;
    bus.mem_valid = 1; bus.mem_addr = addr; bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb; bus.mem_instr = instr;
    lat = 0; seen = 0; done_cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_ready) seen = 1;
    end
    check("req_complete", 32'(seen), 32'd1);
    done_cyc = cyc;
    if (wstrb == 4'b0000 && exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check("mem_rdata", bus.mem_rdata, exp);
    end
    if (!keep) begin
      bus.mem_valid = 0;
      @(negedge clk);
      check("mem_ready_pulse", 32'(bus.mem_ready), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int lat, dc, dc1, a0, aw0, w0, awh0, wh0;
    bit seen;
    bus.mem_valid = 0; bus.mem_instr = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[64] = 32'h1234_5678;
    mem[0]  = 32'h0000_0013;

    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_axi_arvalid,
                           bus.mem_axi_rready, bus.mem_axi_bready, bus.mem_ready,
                           timeout_err, busy}), 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'd0);
    check("rst_addr", bus.mem_axi_awaddr | bus.mem_axi_araddr, 32'd0);
    check("rst_wdata_strb", bus.mem_axi_wdata | 32'(bus.mem_axi_wstrb), 32'd0);
    check("rst_prot", 32'({bus.mem_axi_awprot, bus.mem_axi_arprot}), 32'd0);
    resetn = 1;
    @(negedge clk);

    // Zero-wait data read.
    a0 = ar_n;
    exp_q.push_back(32'h1234_5678);
    do_req(32'h100, '0, 4'b0000, 0, 0, lat, dc);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_arprot", 32'(last_arprot), 32'd0);
    check("rd_ar_count", 32'(ar_n - a0), 32'd1);

    // Instruction fetch.
    a0 = ar_n; aw0 = aw_n; w0 = w_n;
    exp_q.push_back(32'h0000_0013);
    do_req(32'h0, '0, 4'b0000, 1, 0, lat, dc);
    check("if_arprot", 32'(last_arprot), 32'd4);
    check("if_ar_count", 32'(ar_n - a0), 32'd1);
    check("if_no_aw_w", 32'((aw_n - aw0) + (w_n - w0)), 32'd0);

    // Write with W accepted three cycles ahead of AW.
    aw_lat = 3; w_lat = 0;
    awh0 = aw_hi; wh0 = w_hi;
    do_req(32'h40, 32'hDEAD_BEEF, 4'b0101, 0, 0, lat, dc);
    check("wr_aw_held", 32'(aw_hi - awh0), 32'd4);
    check("wr_w_single", 32'(w_hi - wh0), 32'd1);
    check("wr_w_before_aw", 32'(aw_hs_cyc - w_hs_cyc), 32'd3);
    check("wr_bready_after_both", 32'(bready_rise_cyc), 32'(aw_hs_cyc + 1));
    check("wr_ready_after_b", 32'(dc), 32'(b_hs_cyc + 1));
    aw_lat = 0;

    // Read-back of the partially written, pre-zeroed word.
    exp_q.push_back(32'h00AD_00EF);
    do_req(32'h40, '0, 4'b0000, 0, 0, lat, dc);

    // Back-to-back: valid held across DONE, next request presented right away.
    a0 = ar_n;
    exp_q.push_back(32'h1234_5678);
    do_req(32'h100, '0, 4'b0000, 0, 1, lat, dc1);
    exp_q.push_back(32'h0000_0013);
    do_req(32'h0, '0, 4'b0000, 0, 0, lat, dc);
    check("b2b_ar_gap", 32'(arvalid_rise_cyc), 32'(dc1 + 2));
    repeat (3) @(negedge clk);
    check("b2b_ar_count", 32'(ar_n - a0), 32'd2);
    check("no_timeout_yet", 32'(timeout_err), 32'd0);

    // Watchdog: responder withholds arready.
    ar_block = 1;
    exp_q.push_back(32'h1234_5678);
    bus.mem_valid = 1; bus.mem_addr = 32'h100; bus.mem_wstrb = '0; bus.mem_instr = 0;
    repeat (8) @(negedge clk);
    check("wd_before_limit", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("wd_at_limit", 32'(timeout_err), 32'd1);
    check("wd_arvalid_held", 32'(bus.mem_axi_arvalid), 32'd1);
    repeat (4) @(negedge clk);
    ar_block = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_ready) seen = 1;
    end
    check("wd_read_complete", 32'(seen), 32'd1);
    if (seen) check("wd_rdata", bus.mem_rdata, exp_q.pop_front());
    bus.mem_valid = 0;
    @(negedge clk);
    check("wd_sticky", 32'(timeout_err), 32'd1);

    // Reset after the AW handshake while W is still pending.
    w_lat = 6; aw0 = aw_n;
    bus.mem_valid = 1; bus.mem_addr = 32'h80; bus.mem_wdata = 32'hFFFF_FFFF;
    bus.mem_wstrb = 4'hF;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (aw_n != aw0) seen = 1;
    end
    @(negedge clk);
    check("mid_wr_state", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid}), 32'b01);
    resetn = 0;
    bus.mem_valid = 0; bus.mem_wstrb = '0;
    @(negedge clk);
    check("mid_rst_valids", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_axi_arvalid,
                                 bus.mem_axi_rready, bus.mem_axi_bready}), 32'd0);
    check("mid_rst_busy_err", 32'({busy, timeout_err}), 32'd0);
    @(negedge clk);
    resetn = 1; w_lat = 0;
    @(negedge clk);
    exp_q.push_back(32'h1234_5678);
    do_req(32'h100, '0, 4'b0000, 0, 0, lat, dc);
    check("post_rst_latency", 32'(lat), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
